if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction fetch stage for the single-issue MIPS core. It owns the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and holds each fetched instruction for the decode/control stage.
- Presents pre-split fields (OpCode, Func, rs, rt, rd, shamt) to the control decoder and register file.
- Supports downstream stall and PC redirect (branch/jump), with safe discard of an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch byte address, equals current PC while imem_req=1
- imem_ack  in  1  memory has imem_rdata valid this cycle for the outstanding request
- imem_rdata  in  32  instruction word
- stall  in  1  downstream not ready; hold current instruction
- redirect  in  1  load new PC (branch/jump taken)
- redirect_pc  in  32  target PC; bits [1:0] ignored and forced to 0
- instr_valid  out  1  instr and fields hold a valid instruction
- instr  out  32  held instruction word
- pc_out  out  32  address of held instruction
- OpCode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- Func  out  6  instr[5:0]

Behaviour:
- Reset (async, rst_n=0): state=REQ, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, pc_out=0. All field outputs are therefore 0. On the first edge after release, imem_req rises.
- States are REQ, VALID and DISCARD. Field outputs are pure slices of instr. imem_addr=pc at all times.
- REQ:
  - imem_req=1 (from the cycle after entry), instr_valid=0. pc and imem_addr stay stable until ack.
  - Edge with imem_ack=1 and redirect=0: instr<=imem_rdata, pc_out<=pc, pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), instr_valid<=1, imem_req<=0, go to VALID.
  - Edge with redirect=1 and imem_ack=1: data dropped, pc<=redirect_pc&~3, stay in REQ. imem_req stays 1 and the new address is presented next cycle.
  - Edge with redirect=1 and imem_ack=0: go to DISCARD. pc is held at the old address. The target is saved in an internal pend_pc register.
- VALID:
  - instr_valid=1, imem_req=0, and instr/pc_out are held.
  - Edge with redirect=1: instr_valid<=0, pc<=redirect_pc&~3, go to REQ. Redirect has priority over stall.
  - Edge with stall=1: hold everything.
  - Edge with stall=0: instr_valid<=0, go to REQ. Decode consumes the instruction on the edge where instr_valid=1 and stall=0.
- DISCARD:
  - imem_req=1 at the old address, instr_valid=0.
  - On imem_ack=1: data dropped, pc<=pend_pc, go to REQ.
  - A further redirect while in DISCARD overwrites pend_pc (last redirect wins). A redirect on the same edge as the ack also wins.
- Throughput: with zero-wait memory (ack in the first req cycle) and no stall, one instruction every 2 cycles.
- imem_ack while imem_req=0 is ignored.
- stall in REQ or DISCARD has no effect.
- Reset mid-fetch abandons the request immediately. imem_req=0 asynchronously.

Test Plan:
- Reset release, RESET_PC=0, memory acks every req with 32'h0043_2820 (add $5,$2,$3): after 1st ack, instr_valid=1, pc_out=0, OpCode=0, Func=32 (6'h20), rs=2, rt=3, rd=5. The next imem_addr is 4.
- stall=1 held 5 cycles in VALID: instr_valid stays 1, instr unchanged, imem_req=0 throughout. After stall=0, the next fetch goes to address 4.
- Memory with 3 wait cycles: imem_req high 4 cycles with imem_addr constant. Capture happens on the ack cycle only.
- Redirect to 32'h0000_0103 while in VALID: instr_valid drops next cycle, and the next imem_addr=32'h0000_0100.
- Redirect to 0x200 during a pending fetch at 0x8 (no ack), then ack with 32'h0062_202A (slt $4,$3,$2) two cycles later: that data is never presented (instr_valid stays 0). The next request is at 0x200.
- Redirect to 32'hFFFF_FFFC, then ack: pc_out=32'hFFFF_FFFC and the next imem_addr=0. Separately, assert rst_n=0 mid-wait: imem_req=0 and instr_valid=0 immediately, and the first request after release is at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction fetch stage of the single-issue MIPS core.
//
// Owns the PC, fetches one 32-bit word at a time from instruction memory over
// a req/ack handshake, and holds the fetched word (plus its address and the
// pre-split decode fields) until the decode stage consumes it.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   imem_req / imem_addr        registered fetch request, byte address (= pc)
//   imem_ack / imem_rdata       memory response for the outstanding request
//   stall                       decode not ready, hold the current instruction
//   redirect / redirect_pc      branch/jump taken, load new PC (word aligned)
//   instr_valid, instr, pc_out  held instruction and its address
//   OpCode, rs, rt, rd,
//   shamt, Func                 pure slices of instr
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// REQ      | fetching at pc; request raised from the cycle after entry
// VALID    | instruction held for decode, no request outstanding
// DISCARD  | redirect arrived mid-fetch; wait for the stale ack, then jump
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [5:0]  OpCode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  Func
);

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_VALID   = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        imem_req_q, imem_req_d;

   logic [31:0] redirect_tgt;
   logic        ack_v;

   assign redirect_tgt = redirect_pc & PC_ALIGN_MASK;
   // An ack only means something while our request is actually on the bus.
   assign ack_v        = imem_ack & imem_req_q;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC_AL;
         pend_pc_q  <= RESET_PC_AL;
         instr_q    <= 32'h0;
         pc_out_q   <= 32'h0;
         imem_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         imem_req_q <= imem_req_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_REQ: begin
            if (redirect) begin
               // Only a request still waiting for its ack needs discarding.
               if (imem_req_q && !imem_ack) state_d = ST_DISCARD;
               else                         state_d = ST_REQ;
            end else if (ack_v) begin
               state_d = ST_VALID;
            end
         end
         ST_VALID: begin
            if (redirect || !stall) state_d = ST_REQ;
         end
         ST_DISCARD: begin
            if (ack_v) state_d = ST_REQ;
         end
         default: state_d = ST_REQ;
      endcase
   end

   // Datapath / registered-output next values
   always_comb begin
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      // Request is asserted in every cycle spent outside VALID, except the
      // first cycle after reset (register resets low).
      imem_req_d = (state_d != ST_VALID);
      case (state_q)
         ST_REQ: begin
            if (redirect) begin
               if (imem_req_q && !imem_ack) pend_pc_d = redirect_tgt;
               else                         pc_d      = redirect_tgt;
            end else if (ack_v) begin
               instr_d  = imem_rdata;
               pc_out_d = pc_q;
               pc_d     = pc_q + 32'd4;
            end
         end
         ST_VALID: begin
            if (redirect) pc_d = redirect_tgt;
         end
         ST_DISCARD: begin
            if (redirect) pend_pc_d = redirect_tgt;
            // A redirect coinciding with the stale ack is the newest target.
            if (ack_v) pc_d = redirect ? redirect_tgt : pend_pc_q;
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      imem_req    = imem_req_q;
      imem_addr   = pc_q;
      instr_valid = (state_q == ST_VALID);
      instr       = instr_q;
      pc_out      = pc_out_q;
      OpCode      = instr_q[31:26];
      rs          = instr_q[25:21];
      rt          = instr_q[20:16];
      rd          = instr_q[15:11];
      shamt       = instr_q[10:6];
      Func        = instr_q[5:0];
   end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic [5:0]  OpCode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  Func;

   int checks   = 0;
   int failures = 0;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .pc_out      (pc_out),
      .OpCode      (OpCode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .Func        (Func)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld);
      chk({tag, ".req"},   32'(imem_req),    32'(req));
      chk({tag, ".addr"},  imem_addr,        addr);
      chk({tag, ".valid"}, 32'(instr_valid), 32'(vld));
   endtask

   task automatic chk_held(input string tag, input logic [31:0] exp_instr,
                           input logic [31:0] exp_pc, input logic [31:0] next_addr);
      chk({tag, ".valid"},  32'(instr_valid), 32'd1);
      chk({tag, ".instr"},  instr,            exp_instr);
      chk({tag, ".pc_out"}, pc_out,           exp_pc);
      chk({tag, ".req"},    32'(imem_req),    32'd0);
      chk({tag, ".addr"},   imem_addr,        next_addr);
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      #12;

      // reset values
      chk("rst.req",    32'(imem_req),    32'd0);
      chk("rst.valid",  32'(instr_valid), 32'd0);
      chk("rst.instr",  instr,            32'h0);
      chk("rst.pc_out", pc_out,           32'h0);
      chk("rst.opcode", 32'(OpCode),      32'd0);
      chk("rst.func",   32'(Func),        32'd0);
      chk("rst.addr",   imem_addr,        32'h0);

      rst_n = 1'b1;
      tick;
      chk_fetch("first_req", 1'b1, 32'h0, 1'b0);

      // zero-wait fetch of add $5,$2,$3
      imem_ack = 1'b1; imem_rdata = 32'h0043_2820;
      tick;
      imem_ack = 1'b0;
      chk_held("add", 32'h0043_2820, 32'h0, 32'h4);
      chk("add.opcode", 32'(OpCode), 32'd0);
      chk("add.func",   32'(Func),   32'h20);
      chk("add.rs",     32'(rs),     32'd2);
      chk("add.rt",     32'(rt),     32'd3);
      chk("add.rd",     32'(rd),     32'd5);
      chk("add.shamt",  32'(shamt),  32'd0);

      // stall held 5 cycles
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk_held("stall", 32'h0043_2820, 32'h0, 32'h4);
      end
      stall = 1'b0;
      tick;
      chk_fetch("after_stall", 1'b1, 32'h4, 1'b0);

      // three wait cycles: request held 4 cycles at constant address
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_fetch("wait", 1'b1, 32'h4, 1'b0);
      end
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0010;
      tick;
      imem_ack = 1'b0;
      chk_held("lw", 32'h8C22_0010, 32'h4, 32'h8);
      chk("lw.opcode", 32'(OpCode), 32'h23);

      tick;
      chk_fetch("req8", 1'b1, 32'h8, 1'b0);

      // redirect during pending fetch at 0x8
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      tick;
      redirect = 1'b0;
      chk_fetch("discard0", 1'b1, 32'h8, 1'b0);
      tick;
      chk_fetch("discard1", 1'b1, 32'h8, 1'b0);
      imem_ack = 1'b1; imem_rdata = 32'h0062_202A;
      tick;
      imem_ack = 1'b0;
      chk_fetch("stale_drop", 1'b1, 32'h200, 1'b0);
      tick;
      chk_fetch("req200", 1'b1, 32'h200, 1'b0);
      imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
      tick;
      imem_ack = 1'b0;
      chk_held("addi", 32'h2001_0005, 32'h200, 32'h204);

      // redirect in VALID, with stall also high (redirect wins)
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick;
      stall = 1'b0; redirect = 1'b0;
      chk_fetch("redir_valid", 1'b1, 32'h100, 1'b0);
      imem_ack = 1'b1; imem_rdata = 32'h0800_0040;
      tick;
      imem_ack = 1'b0;
      chk_held("j", 32'h0800_0040, 32'h100, 32'h104);
      tick;
      chk_fetch("req104", 1'b1, 32'h104, 1'b0);

      // redirect with ack on the same edge in REQ: data dropped
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick;
      redirect = 1'b0;
      chk_fetch("redir_ack", 1'b1, 32'hFFFF_FFFC, 1'b0);
      imem_rdata = 32'h0000_000C;
      tick;
      imem_ack = 1'b0;
      chk_held("wrap", 32'h0000_000C, 32'hFFFF_FFFC, 32'h0);
      tick;
      chk_fetch("req0", 1'b1, 32'h0, 1'b0);

      // DISCARD: redirect on the ack edge overrides pending target
      redirect = 1'b1; redirect_pc = 32'h0000_0500;
      tick;
      chk_fetch("disc_a", 1'b1, 32'h0, 1'b0);
      redirect_pc = 32'h0000_0601; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick;
      redirect = 1'b0; imem_ack = 1'b0;
      chk_fetch("last_wins", 1'b1, 32'h600, 1'b0);

      // reset in the middle of a wait
      tick;
      #2;
      rst_n = 1'b0;
      #1;
      chk_fetch("mid_rst", 1'b0, 32'h0, 1'b0);
      chk("mid_rst.pc_out", pc_out, 32'h0);

      // ack while imem_req=0 is ignored
      imem_ack = 1'b1; imem_rdata = 32'h0043_2820;
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      chk_fetch("ack_ignored", 1'b1, 32'h0, 1'b0);
      tick;
      imem_ack = 1'b0;
      chk_held("refetch", 32'h0043_2820, 32'h0, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
